// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared defaults, FSM state and read-tag types for the RAM port arbiter.
// Contents: DEF_ADDR_W / DEF_DATA_W defaults, state_t {INIT, ARB}, tag_t {id, rd}.
package ram_arb_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [0:0] {INIT = 1'b0, ARB = 1'b1} state_t;

   typedef struct packed {
      logic id;
      logic rd;
   } tag_t;

endpackage

// File: rtl/ram_arb_grant.sv
// ram_arb_grant: two-requester grant selection, fixed priority or round-robin.
// Ports: valid[1:0] request valids, ptr preferred winner on contention (1 = req1),
//        grant[1:0] one-hot grant (zero when nothing is valid).
// Config: define RAM_ARB_RR_EN for round-robin; otherwise requester 0 wins contention.
module ram_arb_grant
   import ram_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] grant
);

`ifdef RAM_ARB_RR_EN
   always_comb grant = &valid ? (ptr ? 2'b10 : 2'b01) : valid;
`else
   logic unused_ptr;
   assign unused_ptr = ptr;
   always_comb grant = &valid ? 2'b01 : valid;
`endif

endmodule

// File: rtl/ram_port_arb.sv
// ram_port_arb: clears a single-port RAM after reset, then arbitrates two requesters onto it.
// Ports: sys_clk/sys_rst_n (async active-low); reqN_valid/we/addr/wdata in, reqN_ready out;
//        reqN_rvalid/rdata read response; ram_en/we/addr/wr_data to RAM, ram_rd_data from RAM;
//        init_done high once the clear has finished.
// Config: RAM_ARB_RR_EN selects round-robin contention handling (see ram_arb_grant).
module ram_port_arb
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LAT = 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              init_done
);

   state_t            state;
   logic [ADDR_W:0]   init_cnt;
   logic [1:0]        gnt;
   logic              ptr;
   logic              accept;
   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   tag_t              tag_q [RD_LAT+1];
   tag_t              tag_out;

   ram_arb_grant u_grant (
      .valid ({req1_valid, req0_valid}),
      .ptr   (ptr),
      .grant (gnt)
   );

   assign req0_ready = state == ARB && gnt[0];
   assign req1_ready = state == ARB && gnt[1];
   assign accept     = req0_ready || req1_ready;
   assign acc_we     = req1_ready ? req1_we : req0_we;
   assign acc_addr   = req1_ready ? req1_addr : req0_addr;
   assign acc_wdata  = req1_ready ? req1_wdata : req0_wdata;
   assign init_done  = state == ARB;
   assign tag_out    = tag_q[RD_LAT];

   // init_cnt carries one extra bit so the last clear write is still on the bus
   // while the FSM sits in INIT; ARB (and init_done) follow on the next cycle.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= INIT;
         init_cnt    <= '0;
         ptr         <= 1'b0;
         ram_en      <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wr_data <= '0;
      end else if (state == INIT) begin
         ram_en      <= !init_cnt[ADDR_W];
         ram_we      <= !init_cnt[ADDR_W];
         ram_addr    <= init_cnt[ADDR_W-1:0];
         ram_wr_data <= '0;
         init_cnt    <= init_cnt + (ADDR_W+1)'(1);
         if (init_cnt[ADDR_W]) state <= ARB;
      end else begin
         ram_en <= accept;
         ram_we <= accept && acc_we;
         if (accept) begin
            ram_addr    <= acc_addr;
            ram_wr_data <= acc_wdata;
            ptr         <= req0_ready;
         end
      end
   end

   // The tag enters at acceptance and reaches the last stage in the cycle the RAM
   // presents the read data, so the response can be captured and routed by id.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
         req0_rvalid <= 1'b0;
         req1_rvalid <= 1'b0;
         req0_rdata  <= '0;
         req1_rdata  <= '0;
      end else begin
         tag_q[0] <= '{id: req1_ready, rd: accept && !acc_we};
         for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
         req0_rvalid <= tag_out.rd && !tag_out.id;
         req1_rvalid <= tag_out.rd && tag_out.id;
         if (tag_out.rd && !tag_out.id) req0_rdata <= ram_rd_data;
         if (tag_out.rd && tag_out.id) req1_rdata <= ram_rd_data;
      end
   end

endmodule

// File: tb/tb_ram_port_arb.sv
// tb_ram_port_arb: directed bench for ram_port_arb with a one-cycle-latency RAM model.
module tb_ram_port_arb;

   localparam int AW = 5;
   localparam int DW = 8;
`ifdef RAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      logic          v0;
      logic          we0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          v1;
      logic          we1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic [1:0]    fx;
      logic [1:0]    rr;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          r0v, r0w, r1v, r1w;
   logic [AW-1:0] r0a, r1a;
   logic [DW-1:0] r0d, r1d;
   logic          r0rdy, r1rdy, r0rv, r1rv;
   logic [DW-1:0] r0rd, r1rd;
   logic          ram_en, ram_we, init_done;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wr_data;
   logic [DW-1:0] ram_rd_data = '0;
   logic [DW-1:0] mem [2**AW];
   int            n_err = 0;
   int            n_chk = 0;
   vec_t          tbl [10];

   always #5 clk = ~clk;

   ram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
      .sys_clk     (clk),
      .sys_rst_n   (rst_n),
      .req0_valid  (r0v),
      .req0_we     (r0w),
      .req0_addr   (r0a),
      .req0_wdata  (r0d),
      .req0_ready  (r0rdy),
      .req0_rvalid (r0rv),
      .req0_rdata  (r0rd),
      .req1_valid  (r1v),
      .req1_we     (r1w),
      .req1_addr   (r1a),
      .req1_wdata  (r1d),
      .req1_ready  (r1rdy),
      .req1_rvalid (r1rv),
      .req1_rdata  (r1rd),
      .ram_en      (ram_en),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_data (ram_rd_data),
      .init_done   (init_done)
   );

   always @(posedge clk) begin
      if (ram_en && ram_we) mem[ram_addr] <= ram_wr_data;
      if (ram_en && !ram_we) ram_rd_data <= mem[ram_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      r0v = 1'b0; r0w = 1'b0; r0a = '0; r0d = '0;
      r1v = 1'b0; r1w = 1'b0; r1a = '0; r1d = '0;
   endtask

   // Called at the sample point where reset has just been released.
   task automatic init_seq;
      int nz;
      r0v = 1'b1; r0a = 5'd3;
      r1v = 1'b1; r1w = 1'b1; r1a = 5'd9; r1d = 8'h77;
      #1;
      chk("init_c0_en", 32'(ram_en), 32'd0);
      chk("init_c0_rdy", 32'({r1rdy, r0rdy}), 32'd0);
      for (int k = 0; k < 32; k++) begin
         tick;
         chk("init_en_we", 32'({ram_en, ram_we}), 32'b11);
         chk("init_addr", 32'(ram_addr), 32'(k));
         chk("init_wdata", 32'(ram_wr_data), 32'd0);
         chk("init_rdy", 32'({r1rdy, r0rdy}), 32'd0);
         chk("init_done_lo", 32'(init_done), 32'd0);
         chk("init_rvalid", 32'({r1rv, r0rv}), 32'd0);
      end
      idle;
      tick;
      chk("init_done_hi", 32'(init_done), 32'd1);
      chk("init_end_en", 32'(ram_en), 32'd0);
      nz = 0;
      for (int a = 0; a < 2**AW; a++) if (mem[a] != '0) nz++;
      chk("init_clear", 32'(nz), 32'd0);
   endtask

   initial begin
      logic [1:0] exp;
      for (int a = 0; a < 2**AW; a++) mem[a] = 8'hFF;
      idle;
      r0v = 1'b1;
      r1v = 1'b1;
      repeat (3) tick;
      chk("rst_ram", 32'({ram_en, ram_we, ram_addr, ram_wr_data}), 32'd0);
      chk("rst_done", 32'(init_done), 32'd0);
      chk("rst_rdy", 32'({r1rdy, r0rdy}), 32'd0);
      chk("rst_rvalid", 32'({r1rv, r0rv}), 32'd0);
      chk("rst_rdata", 32'({r1rd, r0rd}), 32'd0);
      rst_n = 1'b1;
      init_seq;

      // v0 we0 a0 d0 | v1 we1 a1 d1 | grant fixed | grant round-robin
      tbl[0] = '{1'b1, 1'b1, 5'd4, 8'h10, 1'b0, 1'b0, 5'd0, 8'h00, 2'b01, 2'b01};
      tbl[1] = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd5, 8'h11, 2'b10, 2'b10};
      tbl[2] = '{1'b1, 1'b1, 5'd6, 8'h12, 1'b1, 1'b1, 5'd7, 8'h13, 2'b01, 2'b01};
      tbl[3] = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd7, 8'h13, 2'b10, 2'b10};
      tbl[4] = '{1'b1, 1'b0, 5'd1, 8'h00, 1'b1, 1'b0, 5'd2, 8'h00, 2'b01, 2'b01};
      tbl[5] = '{1'b1, 1'b0, 5'd1, 8'h00, 1'b1, 1'b0, 5'd2, 8'h00, 2'b01, 2'b10};
      tbl[6] = '{1'b1, 1'b0, 5'd1, 8'h00, 1'b1, 1'b0, 5'd2, 8'h00, 2'b01, 2'b01};
      tbl[7] = '{1'b1, 1'b0, 5'd1, 8'h00, 1'b1, 1'b0, 5'd2, 8'h00, 2'b01, 2'b10};
      tbl[8] = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 2'b00, 2'b00};
      tbl[9] = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd9, 8'h00, 2'b10, 2'b10};
      for (int i = 0; i < 10; i++) begin
         r0v = tbl[i].v0; r0w = tbl[i].we0; r0a = tbl[i].a0; r0d = tbl[i].d0;
         r1v = tbl[i].v1; r1w = tbl[i].we1; r1a = tbl[i].a1; r1d = tbl[i].d1;
         exp = RR ? tbl[i].rr : tbl[i].fx;
         #1;
         chk($sformatf("tbl%0d_ready", i), 32'({r1rdy, r0rdy}), 32'(exp));
         tick;
         chk($sformatf("tbl%0d_ram_en", i), 32'(ram_en), 32'(|exp));
         if (|exp) begin
            chk($sformatf("tbl%0d_ram_we", i), 32'(ram_we), 32'(exp[1] ? tbl[i].we1 : tbl[i].we0));
            chk($sformatf("tbl%0d_ram_addr", i), 32'(ram_addr), 32'(exp[1] ? tbl[i].a1 : tbl[i].a0));
            if (exp[1] ? tbl[i].we1 : tbl[i].we0)
               chk($sformatf("tbl%0d_ram_wd", i), 32'(ram_wr_data), 32'(exp[1] ? tbl[i].d1 : tbl[i].d0));
         end else
            chk($sformatf("tbl%0d_ram_we", i), 32'(ram_we), 32'd0);
      end
      idle;
      repeat (4) tick;

      // Write then read the same address on the next cycle.
      r0v = 1'b1; r0w = 1'b1; r0a = 5'd3; r0d = 8'hA5;
      #1;
      chk("raw_wr_ready", 32'(r0rdy), 32'd1);
      tick;
      r0w = 1'b0;
      #1;
      chk("raw_rd_ready", 32'(r0rdy), 32'd1);
      tick;
      idle;
      chk("raw_t1_rvalid", 32'(r0rv), 32'd0);
      tick;
      chk("raw_t2_rvalid", 32'(r0rv), 32'd0);
      tick;
      chk("raw_t3_rvalid", 32'({r1rv, r0rv}), 32'b01);
      chk("raw_t3_rdata", 32'(r0rd), 32'hA5);
      tick;
      chk("raw_t4_rvalid", 32'(r0rv), 32'd0);
      chk("raw_hold_rdata", 32'(r0rd), 32'hA5);
      repeat (2) tick;

      // Four back-to-back req1 reads of the words written by the table.
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("b2b_c%0d_rvalid1", c), 32'(r1rv), 32'(c >= 3 && c <= 6));
         chk($sformatf("b2b_c%0d_rvalid0", c), 32'(r0rv), 32'd0);
         if (c >= 3 && c <= 6)
            chk($sformatf("b2b_c%0d_rdata1", c), 32'(r1rd), 32'h10 + 32'(c - 3));
         if (c < 4) begin
            r1v = 1'b1; r1w = 1'b0; r1a = 5'(4 + c);
            #1;
            chk($sformatf("b2b_c%0d_ready1", c), 32'(r1rdy), 32'd1);
         end else
            idle;
         tick;
      end

      // Reset one cycle after a read acceptance.
      r0v = 1'b1; r0w = 1'b0; r0a = 5'd3;
      #1;
      chk("mid_rd_ready", 32'(r0rdy), 32'd1);
      tick;
      idle;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ram_en", 32'(ram_en), 32'd0);
      chk("mid_rst_rdata", 32'(r0rd), 32'd0);
      chk("mid_rst_done", 32'(init_done), 32'd0);
      tick;
      chk("mid_rst_rvalid", 32'({r1rv, r0rv}), 32'd0);
      tick;
      rst_n = 1'b1;
      init_seq;
      chk("mid_post_rvalid", 32'({r1rv, r0rv}), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ram_port_arb.md
RAM_PORT_ARB -- requirements
Module: ram_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, RAM address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter RD_LAT, default 1, cycles from ram_en-high cycle to valid ram_rd_data.
REQ-004 SHALL have ports:
- sys_clk  in  1  sole clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- reqN_valid  in  1  requester N (N=0,1) access request.
- reqN_we  in  1  1=write, 0=read.
- reqN_addr  in  ADDR_W  access address.
- reqN_wdata  in  DATA_W  write data.
- reqN_ready  out  1  request accepted this cycle.
- reqN_rvalid  out  1  one-cycle read-data strobe.
- reqN_rdata  out  DATA_W  read data, valid with reqN_rvalid.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wr_data  out  DATA_W  RAM write data.
- ram_rd_data  in  DATA_W  RAM read data.
- init_done  out  1  RAM clear complete.

Function
REQ-005 SHALL implement states INIT and ARB; reset enters INIT.
REQ-006 INIT SHALL issue one write of 0 per cycle to addresses 0..2^ADDR_W-1 in ascending order, then enter ARB; INIT lasts exactly 2^ADDR_W cycles.
REQ-007 In INIT, req0_ready and req1_ready SHALL be 0 and init_done SHALL be 0; in ARB, init_done SHALL be 1.
REQ-008 A request SHALL be accepted in a cycle where reqN_valid and reqN_ready are both 1; at most one request SHALL be accepted per cycle.
REQ-009 reqN_ready SHALL be combinational: 1 only in ARB, with reqN_valid=1 and N granted; requesters SHALL hold their request fields stable until accepted.
REQ-010 An accepted request in cycle T SHALL drive ram_en=1, ram_we, ram_addr and ram_wr_data from registers in cycle T+1; with no acceptance, ram_en and ram_we SHALL be 0.
REQ-011 An accepted read in cycle T SHALL assert reqN_rvalid for one cycle at T+2+RD_LAT, with reqN_rdata registered from ram_rd_data. The other requester's rvalid SHALL stay 0 in that cycle.
REQ-012 Writes SHALL produce no response.
REQ-013 Accesses SHALL reach the RAM in acceptance order. A read accepted one cycle after a write to the same address SHALL return the new data.
REQ-014 A per-access tag pipeline (requester id and read flag, depth RD_LAT+1) SHALL route read data. Back-to-back reads SHALL sustain one response per cycle.
REQ-015 With a single requester valid, that requester SHALL be granted.
REQ-016 Simultaneous valid handling SHALL depend on RAM_ARB_RR_EN (REQ-020).
REQ-017 reqN_rdata SHALL hold its last value when reqN_rvalid=0.

Reset
REQ-018 While sys_rst_n=0, the block SHALL drive:
- state INIT, init address 0.
- all ready, rvalid, ram_en, ram_we, init_done: 0.
- ram_addr, ram_wr_data, rdata: 0.
- tag pipeline cleared.
- round-robin pointer pointing to requester 0 as next winner.
REQ-019 Reset asserted mid-operation SHALL discard in-flight reads with no rvalid and restart INIT from address 0 on release.

Configuration
REQ-020 Macro RAM_ARB_RR_EN defined SHALL select round-robin: on simultaneous valid, the requester not granted most recently wins; the pointer updates only on acceptance.
- Undefined, fixed priority SHALL apply: requester 0 always wins simultaneous valid.

Structure
REQ-021 Shared package ram_arb_pkg SHALL hold:
- ADDR_W and DATA_W defaults.
- state enum {INIT, ARB}.
- tag struct {id, rd}.
REQ-022 Grant logic SHALL be a sub-module ram_arb_grant (valids, pointer in; one-hot grant out); the rest stays in ram_port_arb.

Verification
REQ-023 Release reset -> ram_en=1, ram_we=1, ram_wr_data=0 for 32 cycles, addr 0..31; init_done=1 in cycle 33; ready 0 throughout INIT.
REQ-024 req0 writes 0xA5 to addr 3, then reads addr 3 next cycle -> req0_rvalid=1 with req0_rdata=0xA5 exactly RD_LAT+2 cycles after read acceptance.
REQ-025 Both valid reading addr 1 and addr 2 continuously -> RR build alternates grants 0,1,0,1. Fixed build grants only req0; req1_ready=0 while req0_valid=1.
REQ-026 Reads from req1 on 4 consecutive cycles to addr 4..7 (pre-written 0x10..0x13) -> 4 consecutive req1_rvalid cycles, data 0x10..0x13, req0_rvalid stays 0.
REQ-027 Assert reset one cycle after a read acceptance -> no rvalid ever for that read; INIT restarts at addr 0 on release.
